// File: rtl/cordic_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cordic_share_arbiter
// Brief   : Round-robin sharing of one pipelined CORDIC sin/cos core among
//           four requesters, with a tag pipe routing results back.
// Rev     : 1.0 - initial release
// ============================================================================
module cordic_share_arbiter #(
   parameter int ANGLE_W        = 13,
   parameter int RES_W          = 12,
   parameter int CORDIC_LATENCY = 16,
   parameter int MAX_OUT        = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ce,
   input  logic [3:0]           req_valid,
   input  logic [4*ANGLE_W-1:0] req_angle,
   output logic [3:0]           req_ready,
   output logic [ANGLE_W-1:0]   cordic_angle,
   output logic                 cordic_in_valid,
   input  logic [RES_W-1:0]     cordic_sin,
   input  logic [RES_W-1:0]     cordic_cos,
   input  logic                 cordic_valid,
   output logic [3:0]           rsp_valid,
   output logic [RES_W-1:0]     rsp_sin,
   output logic [RES_W-1:0]     rsp_cos,
   output logic [1:0]           rsp_id,
   output logic                 busy,
   output logic                 tag_err
);

   localparam int c_CNT_W  = $clog2(MAX_OUT + 1);
   localparam int c_WARM_W = $clog2(CORDIC_LATENCY + 1);

   logic [1:0]                r_ptr;
   logic [c_CNT_W-1:0]        r_cnt [4];
   logic [CORDIC_LATENCY-1:0] r_tag_v;
   logic [1:0]                r_tag_id [CORDIC_LATENCY];
   logic [c_WARM_W-1:0]       r_warm;

   logic [3:0] w_elig;
   logic [3:0] w_rsp_hit;
   logic [3:0] w_grant;
   logic [1:0] w_gid;
   logic       w_gnt;
   logic       w_last_v;
   logic [1:0] w_last_id;

   assign w_last_v  = r_tag_v[CORDIC_LATENCY-1];
   assign w_last_id = r_tag_id[CORDIC_LATENCY-1];

   for (genvar gi = 0; gi < 4; gi++) begin : g_req
      assign w_elig[gi]    = req_valid[gi] && (r_cnt[gi] < c_CNT_W'(MAX_OUT));
      assign w_rsp_hit[gi] = w_last_v && (w_last_id == 2'(gi));
   end

   // Scan from the highest offset down so the lowest offset from r_ptr wins.
   always_comb begin
      w_gnt = 1'b0;
      w_gid = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         if (w_elig[r_ptr + 2'(k)]) begin
            w_gnt = 1'b1;
            w_gid = r_ptr + 2'(k);
         end
      end
      if (!ce || reset) w_gnt = 1'b0;
      w_grant = w_gnt ? (4'b0001 << w_gid) : 4'b0000;
   end

   assign req_ready = w_grant;
   assign busy      = |r_tag_v;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ptr           <= 2'd0;
         r_tag_v         <= '0;
         r_warm          <= '0;
         cordic_angle    <= '0;
         cordic_in_valid <= 1'b0;
         rsp_valid       <= 4'b0000;
         rsp_sin         <= '0;
         rsp_cos         <= '0;
         rsp_id          <= 2'd0;
         tag_err         <= 1'b0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
         for (int s = 0; s < CORDIC_LATENCY; s++) r_tag_id[s] <= 2'd0;
      end else if (ce) begin
         cordic_in_valid <= w_gnt;
         if (w_gnt) begin
            r_ptr        <= w_gid + 2'd1;
            cordic_angle <= req_angle[int'(w_gid) * ANGLE_W +: ANGLE_W];
         end

         r_tag_v     <= {r_tag_v[CORDIC_LATENCY-2:0], w_gnt};
         r_tag_id[0] <= w_gid;
         for (int s = 1; s < CORDIC_LATENCY; s++) r_tag_id[s] <= r_tag_id[s-1];

         if (w_last_v) begin
            rsp_sin   <= cordic_sin;
            rsp_cos   <= cordic_cos;
            rsp_id    <= w_last_id;
            rsp_valid <= 4'b0001 << w_last_id;
         end else begin
            rsp_valid <= 4'b0000;
         end

         for (int i = 0; i < 4; i++) begin
            if (w_grant[i] && !w_rsp_hit[i])
               r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
            else if (!w_grant[i] && w_rsp_hit[i])
               r_cnt[i] <= r_cnt[i] - c_CNT_W'(1);
         end

         // Core outputs from angles launched before reset drain during this window.
         if (r_warm != c_WARM_W'(CORDIC_LATENCY))
            r_warm <= r_warm + c_WARM_W'(1);
         else if (w_last_v != cordic_valid)
            tag_err <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cordic_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cordic_share_arbiter
// Brief   : Directed self-checking bench with a fixed-latency core model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_cordic_share_arbiter;

   localparam int ANGLE_W = 13;
   localparam int RES_W   = 12;
   localparam int LAT     = 16;
   localparam int MAX_OUT = 8;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 ce;
   logic [3:0]           req_valid;
   logic [4*ANGLE_W-1:0] req_angle;
   logic [3:0]           req_ready;
   logic [ANGLE_W-1:0]   cordic_angle;
   logic                 cordic_in_valid;
   logic [RES_W-1:0]     cordic_sin;
   logic [RES_W-1:0]     cordic_cos;
   logic                 cordic_valid;
   logic [3:0]           rsp_valid;
   logic [RES_W-1:0]     rsp_sin;
   logic [RES_W-1:0]     rsp_cos;
   logic [1:0]           rsp_id;
   logic                 busy;
   logic                 tag_err;
   logic                 spur;

   int tests = 0;
   int fails = 0;

   cordic_share_arbiter #(
      .ANGLE_W(ANGLE_W), .RES_W(RES_W), .CORDIC_LATENCY(LAT), .MAX_OUT(MAX_OUT)
   ) dut (
      .clock(clock), .reset(reset), .ce(ce),
      .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
      .cordic_angle(cordic_angle), .cordic_in_valid(cordic_in_valid),
      .cordic_sin(cordic_sin), .cordic_cos(cordic_cos), .cordic_valid(cordic_valid),
      .rsp_valid(rsp_valid), .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .rsp_id(rsp_id),
      .busy(busy), .tag_err(tag_err)
   );

   always #5 clock = ~clock;

   // Core model: output appears LAT-1 enabled edges after the launch strobe is seen.
   logic [LAT-2:0] m_v = '0;
   logic [11:0]    m_a [LAT-1];
   always @(posedge clock) begin
      if (ce) begin
         m_v    <= {m_v[LAT-3:0], cordic_in_valid};
         m_a[0] <= cordic_angle[11:0];
         for (int k = 1; k < LAT-1; k++) m_a[k] <= m_a[k-1];
      end
   end
   assign cordic_valid = m_v[LAT-2] | spur;
   assign cordic_sin   = m_a[LAT-2] + 12'd1;
   assign cordic_cos   = ~m_a[LAT-2];

   function automatic logic [11:0] exp_sin(input int a);
      return 12'(a + 1);
   endfunction
   function automatic logic [11:0] exp_cos(input int a);
      return ~12'(a);
   endfunction

   task automatic set_angle(input int i, input int a);
      req_angle[i*ANGLE_W +: ANGLE_W] = 13'(a);
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1; req_valid = 4'b0000; spur = 1'b0; ce = 1'b1;
      repeat (2) @(posedge clock);
      #1; reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; ce = 1'b1; req_valid = 4'b1111; spur = 1'b0; req_angle = '0;
      repeat (3) @(posedge clock);
      #2;
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      tests++; if (cordic_in_valid !== 1'b0 || cordic_angle !== '0) begin fails++; $display("FAIL reset_launch: in_valid=%b angle=%0d want 0/0", cordic_in_valid, cordic_angle); end
      tests++; if (rsp_valid !== 4'b0000 || rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp: valid=%b id=%0d want 0000/0", rsp_valid, rsp_id); end
      tests++; if (rsp_sin !== '0 || rsp_cos !== '0) begin fails++; $display("FAIL reset_data: sin=%h cos=%h want 0/0", rsp_sin, rsp_cos); end
      tests++; if (busy !== 1'b0 || tag_err !== 1'b0) begin fails++; $display("FAIL reset_flags: busy=%b tag_err=%b want 0/0", busy, tag_err); end
      req_valid = 4'b0000;
   endtask

   task automatic test_single();
      int bad;
      do_reset();
      set_angle(0, 100);
      req_valid = 4'b0001;
      #1;
      tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", req_ready); end
      @(posedge clock); #1; req_valid = 4'b0000; #1;
      tests++; if (cordic_in_valid !== 1'b1 || cordic_angle !== 13'd100) begin fails++; $display("FAIL single_launch: in_valid=%b angle=%0d want 1/100", cordic_in_valid, cordic_angle); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
      bad = 0;
      for (int s = 1; s < 17; s++) begin
         if (rsp_valid !== 4'b0000) bad++;
         @(posedge clock); #2;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL single_early_rsp: %0d early cycles want 0", bad); end
      tests++; if (rsp_valid !== 4'b0001 || rsp_id !== 2'd0) begin fails++; $display("FAIL single_rsp: valid=%b id=%0d want 0001/0", rsp_valid, rsp_id); end
      tests++; if (rsp_sin !== exp_sin(100) || rsp_cos !== exp_cos(100)) begin fails++; $display("FAIL single_data: sin=%h cos=%h want %h/%h", rsp_sin, rsp_cos, exp_sin(100), exp_cos(100)); end
      @(posedge clock); #2;
      tests++; if (rsp_valid !== 4'b0000 || rsp_sin !== exp_sin(100)) begin fails++; $display("FAIL single_after: valid=%b sin=%h want 0000/%h", rsp_valid, rsp_sin, exp_sin(100)); end
   endtask

   task automatic test_rotate();
      logic [3:0] exp_r;
      logic [3:0] exp_v;
      int id;
      do_reset();
      for (int i = 0; i < 4; i++) set_angle(i, 400 * i);
      for (int s = 0; s < 30; s++) begin
         req_valid = (s < 12) ? 4'b1111 : 4'b0000;
         #1;
         exp_r = (s < 12) ? (4'b0001 << (s % 4)) : 4'b0000;
         tests++; if (req_ready !== exp_r) begin fails++; $display("FAIL rotate_grant s=%0d: got %b want %b", s, req_ready, exp_r); end
         id    = (s - 17) % 4;
         exp_v = (s >= 17 && s < 29) ? (4'b0001 << id) : 4'b0000;
         tests++; if (rsp_valid !== exp_v) begin fails++; $display("FAIL rotate_rsp s=%0d: got %b want %b", s, rsp_valid, exp_v); end
         if (s >= 17 && s < 29) begin
            tests++;
            if (rsp_id !== 2'(id) || rsp_sin !== exp_sin(400*id) || rsp_cos !== exp_cos(400*id)) begin
               fails++; $display("FAIL rotate_data s=%0d: id=%0d sin=%h cos=%h want %0d/%h/%h", s, rsp_id, rsp_sin, rsp_cos, id, exp_sin(400*id), exp_cos(400*id));
            end
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] exp_r;
      do_reset();
      set_angle(2, 500);
      set_angle(0, 700);
      for (int s = 0; s < 25; s++) begin
         req_valid = {1'b0, 1'b1, 1'b0, (s >= 10 && s <= 12)};
         #1;
         if (s < 8 || s >= 17)        exp_r = 4'b0100;
         else if (s >= 10 && s <= 12) exp_r = 4'b0001;
         else                         exp_r = 4'b0000;
         tests++; if (req_ready !== exp_r) begin fails++; $display("FAIL limit_grant s=%0d: got %b want %b", s, req_ready, exp_r); end
         if (s == 17) begin
            tests++; if (rsp_valid !== 4'b0100 || rsp_sin !== exp_sin(500)) begin fails++; $display("FAIL limit_first_rsp: valid=%b sin=%h want 0100/%h", rsp_valid, rsp_sin, exp_sin(500)); end
         end
         @(posedge clock); #1;
      end
      req_valid = 4'b0000;
      repeat (20) @(posedge clock);
      #1;
   endtask

   task automatic test_ce_toggle();
      logic [3:0] exp_r;
      logic [3:0] exp_v;
      int j;
      do_reset();
      set_angle(0, 1000);
      set_angle(1, 1500);
      for (int s = 0; s < 43; s++) begin
         ce        = (s % 2 == 0);
         req_valid = (s < 8) ? 4'b0011 : 4'b0000;
         #1;
         exp_r = (s < 8 && s % 2 == 0) ? (((s / 2) % 2 == 0) ? 4'b0001 : 4'b0010) : 4'b0000;
         tests++; if (req_ready !== exp_r) begin fails++; $display("FAIL ce_grant s=%0d: got %b want %b", s, req_ready, exp_r); end
         j     = (s - 33) / 2;
         exp_v = (s >= 33 && s <= 40) ? ((j % 2 == 0) ? 4'b0001 : 4'b0010) : 4'b0000;
         if (s >= 17) begin
            tests++; if (rsp_valid !== exp_v) begin fails++; $display("FAIL ce_rsp s=%0d: got %b want %b", s, rsp_valid, exp_v); end
         end
         if (s >= 33 && s <= 40) begin
            tests++;
            if (rsp_sin !== exp_sin((j % 2 == 0) ? 1000 : 1500) || rsp_cos !== exp_cos((j % 2 == 0) ? 1000 : 1500)) begin
               fails++; $display("FAIL ce_data s=%0d: sin=%h cos=%h want %h/%h", s, rsp_sin, rsp_cos, exp_sin((j % 2 == 0) ? 1000 : 1500), exp_cos((j % 2 == 0) ? 1000 : 1500));
            end
         end
         @(posedge clock); #1;
      end
      ce = 1'b1;
      #1;
      tests++; if (tag_err !== 1'b0) begin fails++; $display("FAIL ce_tag_err: got %b want 0", tag_err); end
   endtask

   task automatic test_reset_midstream();
      int bad;
      do_reset();
      for (int i = 0; i < 4; i++) set_angle(i, 10 * (i + 1));
      req_valid = 4'b1111;
      repeat (10) begin @(posedge clock); #1; end
      #1;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      reset = 1'b1;
      #1;
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready_in_reset: got %b want 0000", req_ready); end
      @(posedge clock); #1;
      reset = 1'b0; req_valid = 4'b0000;
      #1;
      tests++; if (busy !== 1'b0 || cordic_in_valid !== 1'b0 || cordic_angle !== '0) begin fails++; $display("FAIL mid_after_reset: busy=%b in_valid=%b angle=%0d want 0/0/0", busy, cordic_in_valid, cordic_angle); end
      tests++; if (rsp_valid !== 4'b0000 || rsp_sin !== '0 || rsp_cos !== '0 || tag_err !== 1'b0) begin fails++; $display("FAIL mid_rsp_reset: valid=%b sin=%h cos=%h err=%b want 0", rsp_valid, rsp_sin, rsp_cos, tag_err); end
      bad = 0;
      for (int s = 0; s < 30; s++) begin
         @(posedge clock); #2;
         if (rsp_valid !== 4'b0000 || tag_err !== 1'b0) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL mid_stale_results: %0d bad cycles want 0", bad); end
   endtask

   task automatic test_tag_err();
      #1;
      tests++; if (tag_err !== 1'b0) begin fails++; $display("FAIL err_before: got %b want 0", tag_err); end
      spur = 1'b1;
      @(posedge clock); #1;
      spur = 1'b0;
      #1;
      tests++; if (tag_err !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", tag_err); end
      repeat (5) @(posedge clock);
      #2;
      tests++; if (tag_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", tag_err); end
      do_reset();
      #1;
      tests++; if (tag_err !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", tag_err); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotate();
      test_backpressure();
      test_ce_toggle();
      test_reset_midstream();
      test_tag_err();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
